// File: rtl/blur_frame_arbiter.sv
// Frame-granular arbiter sharing one gaussian_blur engine between two pixel FIFOs.
// Define BLUR_ARB_FIXED_PRIO_EN for fixed priority (source 0 first) instead of round-robin.
module blur_frame_arbiter #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in0_empty,
  output logic       in0_rd_en,
  input  logic [7:0] in0_dout,
  input  logic       in1_empty,
  output logic       in1_rd_en,
  input  logic [7:0] in1_dout,
  output logic       eng_in_empty,
  input  logic       eng_in_rd_en,
  output logic [7:0] eng_in_dout,
  input  logic       eng_out_wr_en,
  input  logic [7:0] eng_out_din,
  output logic       eng_out_full,
  output logic       out_wr_en,
  output logic [7:0] out_din,
  output logic       out_src,
  input  logic       out_full,
  output logic       frame_done,
  output logic       done_src,
  output logic       busy,
  output logic       protocol_err
);
  localparam int PIXEL_COUNT = WIDTH * HEIGHT;
  localparam int CW = $clog2(PIXEL_COUNT + 1);
  localparam logic [CW-1:0] PC = CW'(PIXEL_COUNT);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  state_t        state;
  logic          grant, last_grant;
  logic [CW-1:0] in_cnt, out_cnt, in_cnt_nxt, out_cnt_nxt;
  logic          pend0, pend1, next_grant, rd_fire, wr_count, err_set;

  assign pend0 = !in0_empty;
  assign pend1 = !in1_empty;

`ifdef BLUR_ARB_FIXED_PRIO_EN
  assign next_grant = !pend0;
`else
  assign next_grant = (pend0 && pend1) ? ~last_grant : pend1;
`endif

  // Engine input only sees the granted source while streaming; otherwise it reads as empty.
  always_comb begin
    eng_in_empty = 1'b1;
    eng_in_dout  = grant ? in1_dout : in0_dout;
    in0_rd_en    = 1'b0;
    in1_rd_en    = 1'b0;
    if (state == STREAM) begin
      eng_in_empty = grant ? in1_empty : in0_empty;
      in0_rd_en    = !grant && eng_in_rd_en;
      in1_rd_en    = grant && eng_in_rd_en;
    end
  end

  assign out_wr_en    = eng_out_wr_en;
  assign out_din      = eng_out_din;
  assign out_src      = grant;
  assign eng_out_full = out_full;
  assign busy         = (state != IDLE);

  assign rd_fire  = (state == STREAM) && eng_in_rd_en && !eng_in_empty;
  assign wr_count = (state != IDLE) && eng_out_wr_en;

  assign in_cnt_nxt  = (rd_fire && in_cnt != PC)   ? in_cnt + CW'(1)  : in_cnt;
  assign out_cnt_nxt = (wr_count && out_cnt != PC) ? out_cnt + CW'(1) : out_cnt;

  assign err_set = (eng_out_wr_en && state == IDLE) ||
                   (eng_out_wr_en && out_full) ||
                   (wr_count && out_cnt_nxt > in_cnt_nxt);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= 1'b0;
      last_grant   <= 1'b1;
      in_cnt       <= '0;
      out_cnt      <= '0;
      frame_done   <= 1'b0;
      done_src     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (err_set) protocol_err <= 1'b1;
      case (state)
        IDLE: begin
          if (pend0 || pend1) begin
            grant <= next_grant;
            state <= STREAM;
          end
        end
        STREAM: begin
          in_cnt  <= in_cnt_nxt;
          out_cnt <= out_cnt_nxt;
          if (in_cnt_nxt == PC) state <= DRAIN;
        end
        DRAIN: begin
          // Hold the engine off the next frame until every padded output has left.
          if (out_cnt_nxt == PC) begin
            frame_done <= 1'b1;
            done_src   <= grant;
            last_grant <= grant;
            in_cnt     <= '0;
            out_cnt    <= '0;
            state      <= IDLE;
          end else begin
            out_cnt <= out_cnt_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_blur_frame_arbiter.sv
// Directed bench: FIFO + engine behavioural models with an output scoreboard.
module tb_blur_frame_arbiter;
  localparam int W = 8, H = 4, PC = W * H, LAG = 3;

  logic clock = 1'b0, reset = 1'b1;
  logic in0_empty, in0_rd_en, in1_empty, in1_rd_en;
  logic [7:0] in0_dout, in1_dout, eng_in_dout, eng_out_din, out_din;
  logic eng_in_empty, eng_in_rd_en, eng_out_wr_en, eng_out_full;
  logic out_wr_en, out_src, out_full, frame_done, done_src, busy, protocol_err;

  blur_frame_arbiter #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock(clock), .reset(reset),
    .in0_empty(in0_empty), .in0_rd_en(in0_rd_en), .in0_dout(in0_dout),
    .in1_empty(in1_empty), .in1_rd_en(in1_rd_en), .in1_dout(in1_dout),
    .eng_in_empty(eng_in_empty), .eng_in_rd_en(eng_in_rd_en), .eng_in_dout(eng_in_dout),
    .eng_out_wr_en(eng_out_wr_en), .eng_out_din(eng_out_din), .eng_out_full(eng_out_full),
    .out_wr_en(out_wr_en), .out_din(out_din), .out_src(out_src), .out_full(out_full),
    .frame_done(frame_done), .done_src(done_src), .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  int checks = 0, errors = 0;
  logic [7:0] q0[$], q1[$], sb0[$], sb1[$], ebuf[$];
  bit exp_order[$];
  int er = 0, ew = 0, fo_cnt = 0, frames = 0;
  bit rnd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Pushes one frame into a source FIFO and its expected engine output to the scoreboard.
  task automatic load_frame(input bit s, input logic [7:0] seed, input bit flat);
    logic [7:0] v;
    for (int i = 0; i < PC; i++) begin
      v = flat ? seed : seed + 8'(i * 7);
      if (s) begin q1.push_back(v); sb1.push_back(v + 8'h11); end
      else   begin q0.push_back(v); sb0.push_back(v + 8'h11); end
    end
    exp_order.push_back(s);
  endtask

  task automatic wait_frames(input int target, input int budget);
    for (int c = 0; c < budget && frames < target; c++) tick();
    chk("frame_count", frames, target);
  endtask

  // Source FIFOs and a greedy engine: reads whenever input is non-empty, writes
  // +0x11 of each pixel after LAG pixels, and drains its buffer after the last read.
  always begin
    @(negedge clock);
    if (reset) begin
      eng_in_rd_en = 1'b0; eng_out_wr_en = 1'b0; eng_out_din = 8'h00;
      in0_empty = 1'b1; in1_empty = 1'b1; in0_dout = 8'h00; in1_dout = 8'h00;
    end else begin
      logic [7:0] e;
      bit cs;
      in0_empty = (q0.size() == 0) || (rnd && busy && $urandom_range(0, 3) == 0);
      in1_empty = (q1.size() == 0) || (rnd && busy && $urandom_range(0, 3) == 0);
      in0_dout  = q0.size() ? q0[0] : 8'h00;
      in1_dout  = q1.size() ? q1[0] : 8'h00;
      #1;
      eng_in_rd_en  = !eng_in_empty;
      eng_out_wr_en = !eng_out_full && ebuf.size() > 0 && ((er - ew) > LAG || er == PC) &&
                      (!rnd || $urandom_range(0, 3) != 0);
      eng_out_din   = ebuf.size() ? ebuf[0] : 8'h00;
      #1;
      cs = exp_order.size() ? exp_order[0] : 1'b0;
      chk("in0_rd_en", in0_rd_en, eng_in_rd_en && exp_order.size() > 0 && cs == 1'b0);
      chk("in1_rd_en", in1_rd_en, eng_in_rd_en && exp_order.size() > 0 && cs == 1'b1);
      chk("out_wr_en", out_wr_en, eng_out_wr_en);
      if (er == PC) chk("drain_empty", eng_in_empty, 1'b1);
      if (eng_in_rd_en) begin
        ebuf.push_back(eng_in_dout + 8'h11);
        er++;
        if (in0_rd_en && !in0_empty) void'(q0.pop_front());
        if (in1_rd_en && !in1_empty) void'(q1.pop_front());
      end
      if (eng_out_wr_en) begin
        if (cs) e = sb1.size() ? sb1.pop_front() : 8'hxx;
        else    e = sb0.size() ? sb0.pop_front() : 8'hxx;
        chk("out_src", out_src, cs);
        chk("out_din", out_din, e);
        fo_cnt++;
        void'(ebuf.pop_front());
        ew++;
        if (ew == PC && er == PC) begin er = 0; ew = 0; end
      end
      if (frame_done) begin
        chk("done_src", done_src, cs);
        chk("frame_outputs", fo_cnt, PC);
        chk("idle_after_done", busy, 1'b0);
        fo_cnt = 0;
        frames++;
        if (exp_order.size()) void'(exp_order.pop_front());
      end
    end
  end

  initial begin
    int snap;
    out_full = 1'b0;
    repeat (3) tick();
    chk("rst_eng_in_empty", eng_in_empty, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_done_src", done_src, 1'b0);
    chk("rst_protocol_err", protocol_err, 1'b0);
    chk("rst_out_src", out_src, 1'b0);
    chk("rst_in0_rd_en", in0_rd_en, 1'b0);
    chk("rst_in1_rd_en", in1_rd_en, 1'b0);

    // Single flat frame from source 0.
    load_frame(1'b0, 8'h40, 1'b1);
    reset = 1'b0;
    wait_frames(1, 400);
    chk("t1_q0_consumed", q0.size(), 0);
    chk("t1_protocol_err", protocol_err, 1'b0);

    // Source 1 arrives while source 0 drains; it must wait for frame_done.
    load_frame(1'b0, 8'h03, 1'b0);
    for (int c = 0; c < 400 && er != PC; c++) tick();
    chk("t3_reached_drain", er, PC);
    load_frame(1'b1, 8'h80, 1'b0);
    wait_frames(3, 600);
    chk("t3_protocol_err", protocol_err, 1'b0);

    // Both sources loaded at reset release, random stalls.
    reset = 1'b1; #1;
    frames = 0;
    rnd = 1'b1;
`ifdef BLUR_ARB_FIXED_PRIO_EN
    load_frame(1'b0, 8'h10, 1'b0); load_frame(1'b0, 8'h20, 1'b0); load_frame(1'b0, 8'h30, 1'b0);
    load_frame(1'b1, 8'h90, 1'b0); load_frame(1'b1, 8'hA0, 1'b0);
    q1.delete(); sb1.delete();
    for (int i = 0; i < PC; i++) begin q1.push_back(8'h90 + 8'(i * 7)); sb1.push_back(8'hA1 + 8'(i * 7)); end
    for (int i = 0; i < PC; i++) begin q1.push_back(8'hA0 + 8'(i * 7)); sb1.push_back(8'hB1 + 8'(i * 7)); end
`else
    load_frame(1'b0, 8'h10, 1'b0); load_frame(1'b1, 8'h90, 1'b0);
    load_frame(1'b0, 8'h20, 1'b0); load_frame(1'b1, 8'hA0, 1'b0);
    load_frame(1'b0, 8'h30, 1'b0);
`endif
    tick();
    reset = 1'b0;
    wait_frames(5, 2500);
    chk("t2_protocol_err", protocol_err, 1'b0);

    // Downstream back-pressure for 50 cycles mid-frame.
    load_frame(1'b1, 8'h55, 1'b0);
    for (int c = 0; c < 400 && fo_cnt < 5; c++) tick();
    chk("t4_started", fo_cnt >= 5, 1'b1);
    out_full = 1'b1;
    snap = fo_cnt;
    repeat (50) begin
      tick();
      chk("t4_no_write", out_wr_en, 1'b0);
    end
    chk("t4_no_progress", fo_cnt, snap);
    chk("t4_protocol_err", protocol_err, 1'b0);
    out_full = 1'b0;
    wait_frames(6, 600);

    // Reset in the middle of a source 0 frame.
    load_frame(1'b0, 8'hC0, 1'b0);
    for (int c = 0; c < 400 && er != 17; c++) tick();
    chk("t5_in_cnt_17", er, 17);
    reset = 1'b1; #1;
    chk("t5_eng_in_empty", eng_in_empty, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_in0_rd_en", in0_rd_en, 1'b0);
    chk("t5_out_src", out_src, 1'b0);
    chk("t5_protocol_err", protocol_err, 1'b0);
    er = 0; ew = 0; fo_cnt = 0;
    ebuf.delete(); q0.delete(); sb0.delete(); exp_order.delete();
    repeat (3) begin
      tick();
      chk("t5_no_frame_done", frame_done, 1'b0);
    end
    load_frame(1'b0, 8'h0F, 1'b0);
    reset = 1'b0;
    wait_frames(7, 600);
    chk("final_protocol_err", protocol_err, 1'b0);
    chk("final_sb_empty", sb0.size() + sb1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/blur_frame_arbiter.md
Name: blur_frame_arbiter

Overview:
Frame-granular round-robin arbiter that shares one gaussian_blur engine between two 8-bit pixel source FIFOs (e.g. two camera streams). The arbiter looks like a FIFO read port to the engine's input, and it forwards the engine's write port downstream with a source tag. Arbitration happens only on frame boundaries. After the granted frame's last input pixel, the arbiter shows empty to the engine until all WIDTH*HEIGHT outputs have been written. This stops the engine's end-of-frame zero padding from consuming the next frame's pixels.

Parameters:
WIDTH, 1280, image width in pixels; must match the engine instance.
HEIGHT, 720, image height in pixels; must match the engine instance.
Derived (localparam) PIXEL_COUNT = WIDTH*HEIGHT; counter width CW = $clog2(PIXEL_COUNT+1).

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
in0_empty  in  1  source 0 FIFO empty
in0_rd_en  out  1  source 0 FIFO read strobe
in0_dout  in  8  source 0 FIFO data
in1_empty  in  1  source 1 FIFO empty
in1_rd_en  out  1  source 1 FIFO read strobe
in1_dout  in  8  source 1 FIFO data
eng_in_empty  out  1  empty presented to the engine
eng_in_rd_en  in  1  engine read strobe
eng_in_dout  out  8  data presented to the engine
eng_out_wr_en  in  1  engine output write strobe
eng_out_din  in  8  engine output pixel
eng_out_full  out  1  full presented to the engine
out_wr_en  out  1  downstream FIFO write strobe
out_din  out  8  downstream pixel
out_src  out  1  source tag of the current pixel
out_full  in  1  downstream FIFO full
frame_done  out  1  one-cycle pulse when a frame's last output has been written
done_src  out  1  source of the completed frame; valid with frame_done
busy  out  1  high in STREAM or DRAIN
protocol_err  out  1  sticky error flag

Behaviour:
- Reset: clock and reset as stated above (reset asynchronous, active-high). All registers clear asynchronously.
  - state=IDLE, grant=0, last_grant=1 (so source 0 wins first), in_cnt=0, out_cnt=0.
  - Registered outputs: frame_done=0, done_src=0, protocol_err=0.
  - Combinational outputs while in reset/IDLE: eng_in_empty=1, in*_rd_en=0, out_wr_en=0, busy=0.
  - The engine must share this reset. Reset mid-frame abandons the frame; no frame_done is issued.
- States:
  - IDLE: a source is pending if its empty=0. If both are pending, grant = ~last_grant. If one is pending, that source is granted. Grant is registered, and the arbiter enters STREAM next cycle (1-cycle arbitration latency). With no source pending, stay in IDLE.
  - STREAM: eng_in_empty = in[grant]_empty; eng_in_dout = in[grant]_dout; in[grant]_rd_en = eng_in_rd_en; the other source's rd_en=0. Each eng_in_rd_en&&!eng_in_empty increments in_cnt. On the cycle in_cnt reaches PIXEL_COUNT, go to DRAIN.
  - DRAIN: eng_in_empty forced 1; both rd_en=0.
    - On the write that makes out_cnt==PIXEL_COUNT: next cycle frame_done=1, done_src=grant, last_grant<=grant, both counters clear, state goes to IDLE.
    - The next grant can occur the cycle after that (IDLE evaluates).
- Output path (combinational, 0 latency, in all states):
  - out_wr_en=eng_out_wr_en; out_din=eng_out_din; out_src=grant; eng_out_full=out_full.
  - out_cnt increments on every eng_out_wr_en in STREAM or DRAIN. Outputs overlap input during STREAM.
- protocol_err (sticky until reset) is set by any of:
  - eng_out_wr_en in IDLE;
  - eng_out_wr_en while out_full=1;
  - out_cnt would exceed in_cnt.
- Counter rules: CW-bit unsigned counters; they never wrap, and they saturate at PIXEL_COUNT.
- A source's empty toggling mid-frame is legal; the engine stalls.
- A source that is non-empty in IDLE but becomes empty before STREAM still holds the grant, and the frame waits.

Optional Feature:
BLUR_ARB_FIXED_PRIO_EN
- Defined: IDLE arbitration is fixed priority. Source 0 always wins when both sources are pending, and last_grant is ignored.
- Undefined: round-robin as specified above.

Test Plan:
- WIDTH=8, HEIGHT=4; only source 0 supplies 32 pixels of value 8'h40 -> engine reads exactly 32; eng_in_empty=1 until out_cnt=32; 32 out_wr_en with out_src=0; one frame_done with done_src=0.
- Both sources hold full frames at reset release -> grant order 0,1,0,1 across 4 frames; done_src sequence 0,1,0,1; no read of source 1 while source 0 is granted.
- Source 1 preloads its next frame during source 0's DRAIN -> in1_rd_en stays 0 until after frame_done; the source 0 frame outputs match a standalone engine run bit-exactly.
- out_full held high for 50 cycles mid-frame -> no out_wr_en, no out_cnt change, protocol_err=0; completion still totals 32 outputs.
- Assert reset at in_cnt=17 -> all outputs return to reset values immediately, no frame_done; the next frame completes normally.
- BLUR_ARB_FIXED_PRIO_EN defined, both sources always pending -> done_src=0 for 3 consecutive frames.
